circuit_frame_packer: RTL and testbench

- Multi-channel successor to the single-channel circuit frame parser.
- Accepts decoded circuit payload bytes tagged with a channel number and buffers each channel into a ping-pong bank.
- On each frame-period sync pulse, swaps banks and emits one framed packet per filled channel: frame_type/frame_len sideband, a 10-byte header, then payload.
- Sits between the LDPC/timeslot de-mapping stage and the downlink frame mux; the output stream has ready/valid backpressure.

---
 rtl/circuit_frame_packer_if.sv | 32 +++
 rtl/circuit_frame_packer.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_circuit_frame_packer.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/circuit_frame_packer_if.sv
// -----------------------------------------------------------------------------
// circuit_frame_packer_if
// Output stream of the circuit frame packer: a byte stream with ready/valid
// backpressure plus the per-frame sideband (type, length, length strobe).
//
//   frame_data      8   output byte
//   frame_data_vld  1   output byte valid
//   frame_data_rdy  1   downstream ready
//   frame_type      8   frame type, held between frame_len_vld pulses
//   frame_len       16  total frame length, held between frame_len_vld pulses
//   frame_len_vld   1   one-cycle strobe per emitted frame
//
// master = packer (producer), slave = downstream frame mux (consumer).
// -----------------------------------------------------------------------------
interface circuit_frame_packer_if;
   logic [7:0]  frame_data;
   logic        frame_data_vld;
   logic        frame_data_rdy;
   logic [7:0]  frame_type;
   logic [15:0] frame_len;
   logic        frame_len_vld;

   modport master (
      output frame_data, frame_data_vld, frame_type, frame_len, frame_len_vld,
      input  frame_data_rdy
   );

   modport slave (
      input  frame_data, frame_data_vld, frame_type, frame_len, frame_len_vld,
      output frame_data_rdy
   );
endinterface

// File: rtl/circuit_frame_packer.sv
// -----------------------------------------------------------------------------
// circuit_frame_packer
// Buffers channel-tagged circuit payload bytes into a ping-pong bank and, on
// each frame-period sync pulse, swaps banks and emits one framed packet per
// filled channel: sideband strobe, 10-byte header, then DATA_LEN payload bytes.
//
// Ports:
//   sys_clk     in   system clock
//   rst         in   synchronous reset, active-high
//   sync_pulse  in   one-cycle frame-period boundary
//   din         in   payload byte
//   din_vld     in   din valid
//   din_ch      in   channel of din (CH_W bits)
//   fo          if   output stream + frame sideband (master side)
//   busy        out  emission in progress
//   ovf_cnt     out  dropped input bytes, saturating
//   miss_cnt    out  sync pulses seen while busy, saturating
//   frame_cnt   out  frames fully emitted, saturating
// -----------------------------------------------------------------------------
module circuit_frame_packer #(
   parameter int          CH_NUM       = 4,
   parameter int          DATA_LEN     = 48,
   parameter int          HEAD_LEN     = 10,
   parameter logic [7:0]  FRAME_TYPE   = 8'h0D,
   parameter logic [15:0] LINK_ID_BASE = 16'h0001,
   parameter logic [23:0] SRC_ADDR     = 24'hFFFFFF,
   parameter logic [23:0] DST_ADDR     = 24'hFFFFFF,
   parameter bit          PAD_PARTIAL  = 1'b0,
   localparam int         CH_W         = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 sync_pulse,
   input  logic [7:0]           din,
   input  logic                 din_vld,
   input  logic [CH_W-1:0]      din_ch,
   circuit_frame_packer_if.master fo,
   output logic                 busy,
   output logic [15:0]          ovf_cnt,
   output logic [15:0]          miss_cnt,
   output logic [15:0]          frame_cnt
);

   localparam int CNT_W      = $clog2(DATA_LEN + 1);
   localparam int TOTAL      = HEAD_LEN + DATA_LEN;
   localparam int BEAT_W     = $clog2(TOTAL + 1);
   localparam int BANK_WORDS = CH_NUM * DATA_LEN;
   localparam int DEPTH      = 2 * BANK_WORDS;
   localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [CNT_W-1:0]  DLEN_C  = CNT_W'(DATA_LEN);
   localparam logic [BEAT_W-1:0] TOTAL_C = BEAT_W'(TOTAL);
   localparam logic [BEAT_W-1:0] HLEN_C  = BEAT_W'(HEAD_LEN);
   localparam logic [15:0]       FLEN_C  = 16'(TOTAL);
   localparam logic [CH_W-1:0]   CH_LAST = CH_W'(CH_NUM - 1);
   localparam logic [CH_W:0]     CHN_C   = (CH_W + 1)'(CH_NUM);

   typedef enum logic [2:0] {IDLE, SCAN, LEN, HEAD, PAY, NEXT} state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t            state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [BEAT_W-1:0] beat_q, beat_d;     // next beat to load into the output register
   logic [7:0]        data_q, data_d;
   logic              vld_q, vld_d;
   logic [7:0]        ftype_q, ftype_d;
   logic [15:0]       flen_q, flen_d;
   logic [15:0]       miss_q, miss_d;
   logic [15:0]       fcnt_q, fcnt_d;
   logic [15:0]       ovf_q;
   logic              wr_bank_q;
   logic [CNT_W-1:0]  cnt_q [2][CH_NUM];

   logic [7:0]        mem [DEPTH];
   logic [7:0]        rd_data_q;

   logic              busy_w;
   logic              rd_bank;
   logic              swap, clr_wr;
   logic              ch_ok;
   logic [CH_W-1:0]   ch_idx;
   logic [CNT_W-1:0]  wr_cnt;
   logic              wr_full, wr_en, wr_drop;
   logic [AW-1:0]     wr_addr, rd_addr;
   logic [CNT_W-1:0]  rd_cnt;
   int                rd_idx;
   logic              load;
   logic [7:0]        beat_byte;
   logic [15:0]       link_id;
   logic              rdy;

   assign rdy     = fo.frame_data_rdy;
   assign busy_w  = (state_q != IDLE);
   assign rd_bank = ~wr_bank_q;

   // ---------------------------------------------------------------------------
   // Write side: per-channel fill of the write bank, bank swap on sync
   // ---------------------------------------------------------------------------
   assign swap    = sync_pulse && !busy_w;
   // A sync that arrives mid-emission throws this period's data away.
   assign clr_wr  = sync_pulse && busy_w;
   assign ch_ok   = ({1'b0, din_ch} < CHN_C);
   assign ch_idx  = ch_ok ? din_ch : '0;
   assign wr_cnt  = cnt_q[wr_bank_q][ch_idx];
   assign wr_full = (wr_cnt == DLEN_C);
   assign wr_en   = din_vld && ch_ok && !wr_full && !clr_wr;
   assign wr_drop = din_vld && (!ch_ok || wr_full);
   assign wr_addr = AW'(int'(wr_bank_q) * BANK_WORDS + int'(ch_idx) * DATA_LEN + int'(wr_cnt));

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int c = 0; c < CH_NUM; c++)
               cnt_q[b][c] <= '0;
         wr_bank_q <= 1'b0;
         ovf_q     <= '0;
      end else begin
         // A byte in the sync cycle still lands in the outgoing bank.
         if (wr_en)
            cnt_q[wr_bank_q][ch_idx] <= wr_cnt + 1'b1;
         if (swap) begin
            for (int c = 0; c < CH_NUM; c++)
               cnt_q[rd_bank][c] <= '0;
            wr_bank_q <= ~wr_bank_q;
         end
         if (clr_wr)
            for (int c = 0; c < CH_NUM; c++)
               cnt_q[wr_bank_q][c] <= '0;
         if (wr_drop)
            ovf_q <= sat_inc(ovf_q);
      end
   end

   // ---------------------------------------------------------------------------
   // Buffer RAM: addressed from the next beat index so rd_data_q always holds
   // the payload byte for beat_q, letting the output register reload every
   // cycle without a bubble at the header/payload boundary.
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_idx = 0;
      if (beat_d >= HLEN_C && beat_d < TOTAL_C)
         rd_idx = int'(beat_d - HLEN_C);
   end

   assign rd_addr = AW'(int'(rd_bank) * BANK_WORDS + int'(ch_q) * DATA_LEN + rd_idx);
   assign rd_cnt  = cnt_q[rd_bank][ch_q];

   always_ff @(posedge sys_clk) begin
      if (wr_en)
         mem[wr_addr] <= din;
      rd_data_q <= mem[rd_addr];
   end

   // ---------------------------------------------------------------------------
   // Beat source: fixed header layout, then payload (zero beyond fill count)
   // ---------------------------------------------------------------------------
   always_comb begin
      link_id   = LINK_ID_BASE + 16'(ch_q);
      beat_byte = 8'h00;
      case (int'(beat_q))
         0:       beat_byte = link_id[15:8];
         1:       beat_byte = link_id[7:0];
         2:       beat_byte = SRC_ADDR[23:16];
         3:       beat_byte = SRC_ADDR[15:8];
         4:       beat_byte = SRC_ADDR[7:0];
         5:       beat_byte = DST_ADDR[23:16];
         6:       beat_byte = DST_ADDR[15:8];
         7:       beat_byte = DST_ADDR[7:0];
         8:       beat_byte = FLEN_C[15:8];
         9:       beat_byte = FLEN_C[7:0];
         default: beat_byte = ((int'(beat_q) - HEAD_LEN) < int'(rd_cnt)) ? rd_data_q : 8'h00;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Emission FSM + output register
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      beat_d  = beat_q;
      data_d  = data_q;
      vld_d   = vld_q;
      ftype_d = ftype_q;
      flen_d  = flen_q;
      miss_d  = miss_q;
      fcnt_d  = fcnt_q;
      load    = 1'b0;

      if (vld_q && rdy)
         vld_d = 1'b0;
      if (clr_wr)
         miss_d = sat_inc(miss_q);

      case (state_q)
         IDLE: begin
            if (sync_pulse) begin
               state_d = SCAN;
               ch_d    = '0;
            end
         end
         SCAN: begin
            if (rd_cnt == DLEN_C || (PAD_PARTIAL && rd_cnt != '0)) begin
               state_d = LEN;
               beat_d  = '0;
               // Sideband changes together with the LEN strobe.
               ftype_d = FRAME_TYPE;
               flen_d  = FLEN_C;
            end else begin
               state_d = NEXT;
            end
         end
         LEN: begin
            // Output register is empty here: the previous frame fully drained.
            load    = 1'b1;
            state_d = HEAD;
         end
         HEAD: begin
            if (!vld_q || rdy)
               load = 1'b1;
            if (load && beat_q == HLEN_C - 1'b1)
               state_d = PAY;
         end
         PAY: begin
            if (beat_q != TOTAL_C) begin
               if (!vld_q || rdy)
                  load = 1'b1;
            end else if (vld_q && rdy) begin
               fcnt_d  = sat_inc(fcnt_q);
               state_d = NEXT;
            end
         end
         NEXT: begin
            if (ch_q == CH_LAST) begin
               state_d = IDLE;
            end else begin
               ch_d    = ch_q + 1'b1;
               state_d = SCAN;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         data_d = beat_byte;
         vld_d  = 1'b1;
         beat_d = beat_q + 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q <= IDLE;
         ch_q    <= '0;
         beat_q  <= '0;
         data_q  <= '0;
         vld_q   <= 1'b0;
         ftype_q <= '0;
         flen_q  <= '0;
         miss_q  <= '0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         beat_q  <= beat_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         ftype_q <= ftype_d;
         flen_q  <= flen_d;
         miss_q  <= miss_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign fo.frame_data     = data_q;
   assign fo.frame_data_vld = vld_q;
   assign fo.frame_type     = ftype_q;
   assign fo.frame_len      = flen_q;
   assign fo.frame_len_vld  = (state_q == LEN);
   assign busy              = busy_w;
   assign ovf_cnt           = ovf_q;
   assign miss_cnt          = miss_q;
   assign frame_cnt         = fcnt_q;

endmodule

// File: tb/tb_circuit_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_circuit_frame_packer
// Directed bench. u_m: CH_NUM=4, PAD_PARTIAL=0. u_p: CH_NUM=5, PAD_PARTIAL=1
// (the extra channel-select bit lets an out-of-range channel be driven).
// Stimulus is shared; en_m/en_p gate which instance sees din_vld/sync_pulse.
// -----------------------------------------------------------------------------
module tb_circuit_frame_packer;

   logic       sys_clk = 1'b0;
   logic       rst = 1'b1;
   logic       sync = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_vld = 1'b0;
   logic [2:0] ch = 3'd0;
   logic       en_m = 1'b1;
   logic       en_p = 1'b0;

   wire        vld_m  = din_vld & en_m;
   wire        sync_m = sync & en_m;
   wire        vld_p  = din_vld & en_p;
   wire        sync_p = sync & en_p;

   logic        busy_m, busy_p;
   logic [15:0] ovf_m, miss_m, fcnt_m;
   logic [15:0] ovf_p, miss_p, fcnt_p;

   circuit_frame_packer_if if_m ();
   circuit_frame_packer_if if_p ();

   circuit_frame_packer #(.CH_NUM(4), .PAD_PARTIAL(1'b0)) u_m (
      .sys_clk(sys_clk), .rst(rst), .sync_pulse(sync_m),
      .din(din), .din_vld(vld_m), .din_ch(ch[1:0]),
      .fo(if_m), .busy(busy_m),
      .ovf_cnt(ovf_m), .miss_cnt(miss_m), .frame_cnt(fcnt_m)
   );

   circuit_frame_packer #(.CH_NUM(5), .PAD_PARTIAL(1'b1)) u_p (
      .sys_clk(sys_clk), .rst(rst), .sync_pulse(sync_p),
      .din(din), .din_vld(vld_p), .din_ch(ch),
      .fo(if_p), .busy(busy_p),
      .ovf_cnt(ovf_p), .miss_cnt(miss_p), .frame_cnt(fcnt_p)
   );

   always #5 sys_clk = ~sys_clk;

   // ---------------- monitor (mid-cycle sampling) ----------------
   int         cyc = 0;
   always @(posedge sys_clk) cyc++;

   logic [7:0] q_m[$];
   logic [7:0] q_p[$];
   int         run_q[$];
   int         dly_q[$];
   int         flv_m = 0;
   int         t_flv = 0;
   int         run = 0;
   int         hold_err = 0;
   logic       pv = 1'b0, pr = 1'b0, prst = 1'b0;
   logic [7:0] pd = 8'h00;

   always @(negedge sys_clk) begin
      if (if_m.frame_len_vld) begin
         flv_m++;
         t_flv = cyc;
      end
      if (if_m.frame_data_vld && !pv)
         dly_q.push_back(cyc - t_flv);
      if (if_m.frame_data_vld)
         run++;
      else if (run != 0) begin
         run_q.push_back(run);
         run = 0;
      end
      if (pv && !pr && !prst && (!if_m.frame_data_vld || if_m.frame_data !== pd))
         hold_err++;
      if (if_m.frame_data_vld && if_m.frame_data_rdy)
         q_m.push_back(if_m.frame_data);
      if (if_p.frame_data_vld && if_p.frame_data_rdy)
         q_p.push_back(if_p.frame_data);
      pv   = if_m.frame_data_vld;
      pr   = if_m.frame_data_rdy;
      pd   = if_m.frame_data;
      prst = rst;
   end

   // ---------------- check helpers ----------------
   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic fill(input logic [2:0] c, input logic [7:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         din     = 8'(start + i);
         ch      = c;
         din_vld = 1'b1;
         tick(1);
      end
      din_vld = 1'b0;
   endtask

   task automatic sync_once();
      sync = 1'b1;
      tick(1);
      sync = 1'b0;
   endtask

   task automatic wait_idle_m(input string tag);
      int n = 0;
      while (busy_m && n < 2000) begin
         tick(1);
         n++;
      end
      check(tag, {31'd0, busy_m}, 32'd0);
   endtask

   task automatic wait_idle_p(input string tag);
      int n = 0;
      while (busy_p && n < 2000) begin
         tick(1);
         n++;
      end
      check(tag, {31'd0, busy_p}, 32'd0);
   endtask

   // Header bytes are the hand-derived layout for SRC=DST=FFFFFF, len=58 (0x003A).
   task automatic exp_frame(input logic [15:0] link, input logic [7:0] start, input int nfill);
      exp_q.push_back(link[15:8]);
      exp_q.push_back(link[7:0]);
      repeat (6) exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h3A);
      for (int i = 0; i < 48; i++)
         exp_q.push_back((i < nfill) ? 8'(start + i) : 8'h00);
   endtask

   task automatic cmp_m(input string tag, input int base);
      int mism = 0;
      check({tag, "_len"}, q_m.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size() && base + i < q_m.size(); i++)
         if (q_m[base + i] !== exp_q[i]) mism++;
      check({tag, "_bytes"}, mism, 0);
   endtask

   task automatic cmp_p(input string tag, input int base);
      int mism = 0;
      check({tag, "_len"}, q_p.size() - base, exp_q.size());
      for (int i = 0; i < exp_q.size() && base + i < q_p.size(); i++)
         if (q_p[base + i] !== exp_q[i]) mism++;
      check({tag, "_bytes"}, mism, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [7:0] hdr0 [10];
      int b, f, r, d, n;
      hdr0 = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h3A};
      if_m.frame_data_rdy = 1'b1;
      if_p.frame_data_rdy = 1'b1;

      // Reset state
      tick(3);
      check("rst_vld",   {31'd0, if_m.frame_data_vld}, 32'd0);
      check("rst_flv",   {31'd0, if_m.frame_len_vld}, 32'd0);
      check("rst_busy",  {31'd0, busy_m}, 32'd0);
      check("rst_flen",  if_m.frame_len, 32'd0);
      check("rst_ftype", if_m.frame_type, 32'd0);
      check("rst_ovf",   ovf_m, 32'd0);
      check("rst_miss",  miss_m, 32'd0);
      check("rst_fcnt",  fcnt_m, 32'd0);
      check("rst_data",  if_m.frame_data, 32'd0);
      rst = 1'b0;
      tick(1);

      // S1: two full channels
      fill(3'd0, 8'h00, 48);
      fill(3'd2, 8'h80, 48);
      exp_q.delete();
      exp_frame(16'h0001, 8'h00, 48);
      exp_frame(16'h0003, 8'h80, 48);
      b = q_m.size(); f = flv_m; r = run_q.size(); d = dly_q.size();
      sync_once();
      check("s1_busy", {31'd0, busy_m}, 32'd1);
      wait_idle_m("s1_idle");
      check("s1_flv_pulses", flv_m - f, 32'd2);
      check("s1_frame_len", if_m.frame_len, 32'd58);
      check("s1_frame_type", if_m.frame_type, 32'h0D);
      for (int i = 0; i < 10; i++)
         check($sformatf("s1_hdr%0d", i), (b + i < q_m.size()) ? q_m[b + i] : 8'hxx, hdr0[i]);
      check("s1_ch2_link_hi", (b + 58 < q_m.size()) ? q_m[b + 58] : 8'hxx, 8'h00);
      check("s1_ch2_link_lo", (b + 59 < q_m.size()) ? q_m[b + 59] : 8'hxx, 8'h03);
      cmp_m("s1", b);
      check("s1_run0", (run_q.size() > r) ? run_q[r] : -1, 32'd58);
      check("s1_run1", (run_q.size() > r + 1) ? run_q[r + 1] : -1, 32'd58);
      check("s1_first_byte_delay", (dly_q.size() > d) ? dly_q[d] : -1, 32'd1);
      check("s1_fcnt", fcnt_m, 32'd2);
      check("s1_ovf", ovf_m, 32'd0);

      // S2: partial channel, skipped without padding
      fill(3'd1, 8'h40, 20);
      b = q_m.size(); f = flv_m;
      sync_once();
      wait_idle_m("s2_idle");
      check("s2_no_bytes", q_m.size() - b, 32'd0);
      check("s2_no_flv", flv_m - f, 32'd0);
      check("s2_fcnt", fcnt_m, 32'd2);

      // S2 with padding instance: 20 data bytes then 28 zeros
      en_m = 1'b0; en_p = 1'b1;
      fill(3'd1, 8'h40, 20);
      exp_q.delete();
      exp_frame(16'h0002, 8'h40, 20);
      b = q_p.size();
      sync_once();
      wait_idle_p("s2p_idle");
      cmp_p("s2p", b);
      check("s2p_fcnt", fcnt_p, 32'd1);
      check("s2p_frame_len", if_p.frame_len, 32'd58);

      // S3: overflow of a full channel plus an out-of-range channel
      fill(3'd0, 8'h00, 50);
      fill(3'd5, 8'hEE, 3);
      check("s3_ovf", ovf_p, 32'd5);
      exp_q.delete();
      exp_frame(16'h0001, 8'h00, 48);
      b = q_p.size();
      sync_once();
      wait_idle_p("s3_idle");
      cmp_p("s3", b);
      check("s3_fcnt", fcnt_p, 32'd2);

      // S4: random backpressure, same byte stream as S1
      en_m = 1'b1; en_p = 1'b0;
      fill(3'd0, 8'h00, 48);
      fill(3'd2, 8'h80, 48);
      exp_q.delete();
      exp_frame(16'h0001, 8'h00, 48);
      exp_frame(16'h0003, 8'h80, 48);
      b = q_m.size();
      sync_once();
      n = 0;
      while (busy_m && n < 3000) begin
         if_m.frame_data_rdy = 1'($urandom_range(0, 1));
         tick(1);
         n++;
      end
      if_m.frame_data_rdy = 1'b1;
      check("s4_idle", {31'd0, busy_m}, 32'd0);
      cmp_m("s4", b);
      check("s4_hold", hold_err, 32'd0);
      check("s4_fcnt", fcnt_m, 32'd4);

      // S5: sync while busy discards the ch3 fill
      fill(3'd0, 8'h20, 48);
      exp_q.delete();
      exp_frame(16'h0001, 8'h20, 48);
      b = q_m.size();
      sync_once();
      if_m.frame_data_rdy = 1'b0;
      fill(3'd3, 8'h60, 48);
      check("s5_busy", {31'd0, busy_m}, 32'd1);
      sync_once();
      check("s5_miss", miss_m, 32'd1);
      if_m.frame_data_rdy = 1'b1;
      wait_idle_m("s5_idle");
      cmp_m("s5", b);
      check("s5_fcnt", fcnt_m, 32'd5);
      check("s5_hold", hold_err, 32'd0);
      b = q_m.size(); f = flv_m;
      sync_once();
      wait_idle_m("s5b_idle");
      check("s5_ch3_discarded", q_m.size() - b, 32'd0);
      check("s5_no_flv", flv_m - f, 32'd0);
      check("s5_fcnt_after", fcnt_m, 32'd5);
      check("s5_miss_after", miss_m, 32'd1);

      // S6: reset at the 5th header byte
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      fill(3'd1, 8'hC0, 48);
      b = q_m.size();
      sync_once();
      n = 0;
      while ((q_m.size() - b) < 4 && n < 200) begin
         tick(1);
         n++;
      end
      check("s6_reach_hdr4", q_m.size() - b, 32'd4);
      check("s6_hdr4_vld", {31'd0, if_m.frame_data_vld}, 32'd1);
      rst = 1'b1;
      if_m.frame_data_rdy = 1'b0;
      tick(1);
      check("s6_vld_after_rst", {31'd0, if_m.frame_data_vld}, 32'd0);
      check("s6_busy_after_rst", {31'd0, busy_m}, 32'd0);
      check("s6_fcnt", fcnt_m, 32'd0);
      rst = 1'b0;
      if_m.frame_data_rdy = 1'b1;
      tick(1);
      b = q_m.size(); f = flv_m;
      sync_once();
      wait_idle_m("s6_empty_idle");
      check("s6_counts_cleared", q_m.size() - b, 32'd0);
      check("s6_no_flv", flv_m - f, 32'd0);
      fill(3'd1, 8'hC0, 48);
      exp_q.delete();
      exp_frame(16'h0002, 8'hC0, 48);
      b = q_m.size();
      sync_once();
      wait_idle_m("s6_idle");
      cmp_m("s6", b);
      check("s6_fcnt_final", fcnt_m, 32'd1);

      tick(2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
